gshare_btb_predictor: RTL and testbench
=======================================

Name: gshare_btb_predictor

Overview:
Parametrised successor to the fetch-stage 2-bit branch predictor. Pairs a gshare (or bimodal) direction table of N-bit saturating counters with a tagged direct-mapped BTB and a speculative global history register. Fetch looks up a direction and a target every cycle; Execute writes back resolved outcomes, repairs history on mispredict, and updates the accuracy statistics.

Parameters:
BHT_INDEX_BITS, 8, log2 of direction-table entries
GHR_BITS, 8, global history length; must be <= BHT_INDEX_BITS
CTR_BITS, 2, counter width; must be >= 1
BTB_INDEX_BITS, 5, log2 of BTB entries
BTB_TAG_BITS, 10, tag width, taken from PC[2+BTB_INDEX_BITS +: BTB_TAG_BITS]
GSHARE, 1, 1 = index PC[2 +: BHT_INDEX_BITS] XOR zero-extended GHR; 0 = PC bits only (bimodal)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pc_f  in  32  fetch PC
fetch_adv  in  1  fetch PC advances this cycle (not stalled or flushed)
pred_taken_f  out  1  predicted redirect
pred_target_f  out  32  predicted next PC
btb_hit_f  out  1  BTB tag match
ghr_f  out  GHR_BITS  history used for this lookup; piped down to Execute
upd_valid  in  1  resolved control-flow instruction in Execute
upd_is_cond  in  1  1 = conditional branch, 0 = jal/jalr
upd_pc  in  32  PC of the resolved instruction
upd_ghr  in  GHR_BITS  ghr_f carried with the instruction
upd_taken  in  1  actual outcome
upd_target  in  32  actual target
upd_pred_taken  in  1  pred_taken_f carried with the instruction
upd_pred_target  in  32  pred_target_f carried with the instruction
mispredict  out  1  combinational: upd_valid and (upd_pred_taken != upd_taken, or both taken and targets differ)
stats_clear  in  1  zero the statistic counters
total_branches  out  32  resolved conditional branches
dir_mispredicts  out  32  conditional direction mispredicts
tgt_mispredicts  out  32  correct-taken predictions with wrong target (all control flow)

Behaviour:
- Reset (synchronous, wins over all inputs): all counters = 2^(CTR_BITS-1) (weakly taken); all BTB valid bits = 0; GHR = 0; statistics = 0. Outputs then follow from the reset state: btb_hit_f = 0, pred_taken_f = 0, pred_target_f = pc_f+4, ghr_f = 0.
- Lookup is combinational from pc_f and current state, with zero latency.
  - Hit and the entry's cond bit set: taken = counter MSB.
  - Hit and cond bit clear: taken = 1.
  - Miss: taken = 0.
  - pred_target_f = taken ? BTB target : pc_f+4.
- Read-during-write: a lookup in the same cycle as a write to the same entry returns the old value. The write takes effect at the edge.
- GHR update, per edge and in priority order:
  1. reset
  2. mispredict on a conditional: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}
  3. mispredict on a jump: GHR <= upd_ghr
  4. fetch_adv with a BTB hit on a cond entry: GHR <= {GHR[GHR_BITS-2:0], pred_taken_f}
  5. otherwise hold
- With GHR_BITS = 1, a shift replaces the single bit.
- Counter update on upd_valid & upd_is_cond:
  - Index is computed from upd_pc and upd_ghr, not the live GHR.
  - Saturating: +1 if taken, -1 if not taken, clamped at 0 and 2^CTR_BITS-1.
- BTB update on upd_valid & upd_taken: write valid=1, tag, target=upd_target, cond=upd_is_cond. The previous occupant is overwritten with no replacement policy.
- BTB invalidation: upd_valid & upd_is_cond & !upd_taken & tag match clears nothing. The entry is retained.
- Statistics:
  - total_branches +1 on upd_valid & upd_is_cond.
  - dir_mispredicts +1 when, in addition, upd_pred_taken != upd_taken.
  - tgt_mispredicts +1 on upd_valid & upd_taken & upd_pred_taken & target mismatch.
  - All three saturate at 32'hFFFFFFFF.
  - stats_clear has priority over increments in the same cycle.
- Simultaneous fetch and update to the same counter or BTB entry: the update writes, and the fetch reads the pre-edge value.

Test Plan:
- Reset, then pc_f=0x100 → btb_hit_f=0, pred_taken_f=0, pred_target_f=0x104, ghr_f=0. Counter at index 0x40 reads 2'b10.
- Resolve cond branch upd_pc=0x100, taken, target 0x80, upd_ghr=0 → next cycle, pc_f=0x100 gives btb_hit_f=1, pred_taken_f=1, pred_target_f=0x80. Counter 0x40 = 2'b11. total_branches=1, dir_mispredicts=1.
- Four not-taken resolutions of 0x100 with upd_ghr=0 → counter goes 11→10→01→00→00 (saturates). Lookup predicts not taken with target 0x104, and the BTB entry is still valid.
- GHR=8'h0F and fetch_adv on a cond hit predicting taken, in the same cycle as a cond mispredict with upd_ghr=8'hA5, upd_taken=0 → GHR=8'h4A (repair wins).
- jal at 0x200 resolved taken to 0x300 → the next lookup of 0x200 is taken with target 0x300. Later resolving it to 0x340 with upd_pred_target=0x300 → mispredict=1, tgt_mispredicts+1, BTB target becomes 0x340, GHR=upd_ghr.
- stats_clear asserted in the same cycle as a counted mispredict → all three statistics read 0 next cycle. With GSHARE=0, two branches differing only in upd_ghr hit the same counter.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: gshare/bimodal direction table, tagged direct-mapped BTB,
// speculative global history with repair from Execute, and resolution statistics.
module gshare_btb_predictor #(
  parameter int BHT_INDEX_BITS = 8,
  parameter int GHR_BITS       = 8,
  parameter int CTR_BITS       = 2,
  parameter int BTB_INDEX_BITS = 5,
  parameter int BTB_TAG_BITS   = 10,
  parameter int GSHARE         = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_f,
  input  logic                fetch_adv,
  output logic                pred_taken_f,
  output logic [31:0]         pred_target_f,
  output logic                btb_hit_f,
  output logic [GHR_BITS-1:0] ghr_f,
  input  logic                upd_valid,
  input  logic                upd_is_cond,
  input  logic [31:0]         upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_pred_taken,
  input  logic [31:0]         upd_pred_target,
  output logic                mispredict,
  input  logic                stats_clear,
  output logic [31:0]         total_branches,
  output logic [31:0]         dir_mispredicts,
  output logic [31:0]         tgt_mispredicts
);
  localparam int BHT_N = 1 << BHT_INDEX_BITS;
  localparam int BTB_N = 1 << BTB_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_ONE << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]     bht       [BHT_N];
  logic                    btb_valid [BTB_N];
  logic                    btb_cond  [BTB_N];
  logic [BTB_TAG_BITS-1:0] btb_tag   [BTB_N];
  logic [31:0]             btb_tgt   [BTB_N];
  logic [GHR_BITS-1:0]     ghr;

  function automatic logic [BHT_INDEX_BITS-1:0] bht_idx(input logic [31:0] pc,
                                                        input logic [GHR_BITS-1:0] h);
    logic [BHT_INDEX_BITS-1:0] hx;
    hx = '0;
    hx[GHR_BITS-1:0] = h;
    return (GSHARE != 0) ? (pc[2 +: BHT_INDEX_BITS] ^ hx) : pc[2 +: BHT_INDEX_BITS];
  endfunction

  logic [BHT_INDEX_BITS-1:0] f_bidx, u_bidx;
  logic [BTB_INDEX_BITS-1:0] f_tidx, u_tidx;
  logic [BTB_TAG_BITS-1:0]   f_tag, u_tag;
  logic [CTR_BITS-1:0]       ctr_old, ctr_new;
  logic [GHR_BITS:0]         rep_sh, spec_sh;
  logic                      tgt_miss, unused_pc;

  assign f_bidx = bht_idx(pc_f, ghr);
  assign u_bidx = bht_idx(upd_pc, upd_ghr);
  assign f_tidx = pc_f[2 +: BTB_INDEX_BITS];
  assign u_tidx = upd_pc[2 +: BTB_INDEX_BITS];
  assign f_tag  = pc_f[2+BTB_INDEX_BITS +: BTB_TAG_BITS];
  assign u_tag  = upd_pc[2+BTB_INDEX_BITS +: BTB_TAG_BITS];
  assign unused_pc = ^{pc_f, upd_pc};

  // Lookup reads pre-edge state, so a same-cycle update is never forwarded.
  assign btb_hit_f     = btb_valid[f_tidx] && (btb_tag[f_tidx] == f_tag);
  assign pred_taken_f  = btb_hit_f && (btb_cond[f_tidx] ? bht[f_bidx][CTR_BITS-1] : 1'b1);
  assign pred_target_f = pred_taken_f ? btb_tgt[f_tidx] : pc_f + 32'd4;
  assign ghr_f         = ghr;

  assign tgt_miss   = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
  assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) || tgt_miss);

  // Widening by one bit keeps the shift legal when GHR_BITS == 1.
  assign rep_sh  = {upd_ghr, upd_taken};
  assign spec_sh = {ghr, pred_taken_f};

  assign ctr_old = bht[u_bidx];
  always_comb begin
    ctr_new = ctr_old;
    if (upd_taken && ctr_old != CTR_MAX)  ctr_new = ctr_old + CTR_ONE;
    if (!upd_taken && ctr_old != '0)      ctr_new = ctr_old - CTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (mispredict && upd_is_cond) begin
      ghr <= rep_sh[GHR_BITS-1:0];
    end else if (mispredict) begin
      ghr <= upd_ghr;
    end else if (fetch_adv && btb_hit_f && btb_cond[f_tidx]) begin
      ghr <= spec_sh[GHR_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= CTR_INIT;
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cond[i]  <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
      end
    end else begin
      if (upd_valid && upd_is_cond) bht[u_bidx] <= ctr_new;
      if (upd_valid && upd_taken) begin
        btb_valid[u_tidx] <= 1'b1;
        btb_cond[u_tidx]  <= upd_is_cond;
        btb_tag[u_tidx]   <= u_tag;
        btb_tgt[u_tidx]   <= upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      total_branches  <= '0;
      dir_mispredicts <= '0;
      tgt_mispredicts <= '0;
    end else if (upd_valid) begin
      if (upd_is_cond && total_branches != '1)
        total_branches <= total_branches + 32'd1;
      if (upd_is_cond && (upd_pred_taken != upd_taken) && dir_mispredicts != '1)
        dir_mispredicts <= dir_mispredicts + 32'd1;
      if (tgt_miss && tgt_mispredicts != '1)
        tgt_mispredicts <= tgt_mispredicts + 32'd1;
    end
  end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench: gshare instance for most checks, a bimodal instance for index aliasing.
module tb_gshare_btb_predictor;
  logic        clk = 0, reset = 1, fetch_adv = 0, stats_clear = 0;
  logic [31:0] pc_f = 0;
  logic        upd_valid = 0, upd_is_cond = 0, upd_taken = 0, upd_pred_taken = 0;
  logic [31:0] upd_pc = 0, upd_target = 0, upd_pred_target = 0;
  logic [7:0]  upd_ghr = 0;

  logic        a_taken, a_hit, a_misp, b_taken, b_hit, b_misp;
  logic [31:0] a_target, a_total, a_dir, a_tgt, b_target, b_total, b_dir, b_tgt;
  logic [7:0]  a_ghr, b_ghr;

  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  gshare_btb_predictor #(.GSHARE(1)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .fetch_adv(fetch_adv),
    .pred_taken_f(a_taken), .pred_target_f(a_target), .btb_hit_f(a_hit), .ghr_f(a_ghr),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(a_misp), .stats_clear(stats_clear),
    .total_branches(a_total), .dir_mispredicts(a_dir), .tgt_mispredicts(a_tgt));

  gshare_btb_predictor #(.GSHARE(0)) dut_bim (
    .clk(clk), .reset(reset), .pc_f(pc_f), .fetch_adv(fetch_adv),
    .pred_taken_f(b_taken), .pred_target_f(b_target), .btb_hit_f(b_hit), .ghr_f(b_ghr),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(b_misp), .stats_clear(stats_clear),
    .total_branches(b_total), .dir_mispredicts(b_dir), .tgt_mispredicts(b_tgt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 0; stats_clear = 0; fetch_adv = 0;
  endtask

  task automatic upd(input logic c, input logic [31:0] pc, input logic [7:0] h, input logic t,
                     input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    upd_valid = 1; upd_is_cond = c; upd_pc = pc; upd_ghr = h; upd_taken = t;
    upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_f = pc;
    #1;
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    look(32'h100);
    chk("rst_hit", a_hit, 0);
    chk("rst_taken", a_taken, 0);
    chk("rst_target", a_target, 32'h104);
    chk("rst_ghr", a_ghr, 0);
    chk("rst_total", a_total, 0);
    chk("rst_dir", a_dir, 0);
    chk("rst_tgt", a_tgt, 0);
    chk("rst_misp", a_misp, 0);

    // first resolution: weakly-taken counter goes strong, BTB fills, history repaired to 0x01
    upd(1, 32'h100, 8'h00, 1, 32'h80, 0, 32'h104); #1;
    chk("cond_misp", a_misp, 1);
    tick(); look(32'h100);
    chk("fill_hit", a_hit, 1);
    chk("fill_taken", a_taken, 1);
    chk("fill_target", a_target, 32'h80);
    chk("fill_ghr", a_ghr, 8'h01);
    chk("fill_total", a_total, 1);
    chk("fill_dir", a_dir, 1);
    chk("fill_tgt", a_tgt, 0);

    // 11 -> 10 -> 01 -> 00 -> 00; only the first step still predicts taken
    for (int i = 0; i < 4; i++) begin
      upd(1, 32'h100, 8'h00, 0, 32'h0, 1, 32'h80);
      tick(); look(32'h100);
      chk($sformatf("sat_taken%0d", i), a_taken, (i == 0) ? 1 : 0);
      chk($sformatf("sat_ghr%0d", i), a_ghr, 0);
    end
    chk("sat_hit", a_hit, 1);
    chk("sat_target", a_target, 32'h104);
    chk("sat_total", a_total, 5);
    chk("sat_dir", a_dir, 5);

    // jump repair sets history to 0x07, then speculative shift on a cond hit
    upd(0, 32'h404, 8'h07, 1, 32'h480, 0, 32'h408);
    tick(); look(32'h100);
    chk("jmp_ghr", a_ghr, 8'h07);
    chk("spec_taken", a_taken, 1);
    fetch_adv = 1;
    tick(); look(32'h100);
    chk("spec_ghr", a_ghr, 8'h0F);

    // repair beats speculative shift in the same cycle
    fetch_adv = 1;
    upd(1, 32'h500, 8'hA5, 0, 32'h0, 1, 32'h580); #1;
    chk("prio_taken", a_taken, 1);
    tick();
    chk("prio_ghr", a_ghr, 8'h4A);
    chk("prio_total", a_total, 6);

    // jal fill, evicts 0x100 (same BTB set), then target mispredict
    upd(0, 32'h200, 8'h33, 1, 32'h300, 0, 32'h204); #1;
    chk("jal_misp", a_misp, 1);
    tick(); look(32'h200);
    chk("jal_hit", a_hit, 1);
    chk("jal_taken", a_taken, 1);
    chk("jal_target", a_target, 32'h300);
    chk("jal_ghr", a_ghr, 8'h33);
    look(32'h100);
    chk("evict_hit", a_hit, 0);
    upd(0, 32'h200, 8'h5C, 1, 32'h340, 1, 32'h300); #1;
    chk("tgt_misp", a_misp, 1);
    tick(); look(32'h200);
    chk("tgt_target", a_target, 32'h340);
    chk("tgt_ghr", a_ghr, 8'h5C);
    chk("tgt_cnt", a_tgt, 1);
    chk("tgt_total", a_total, 6);
    upd(0, 32'h200, 8'h5C, 1, 32'h340, 1, 32'h340); #1;
    chk("ok_misp", a_misp, 0);
    tick();
    chk("ok_tgt", a_tgt, 1);

    // clear wins over a counted mispredict; same-cycle lookup sees the old BTB
    look(32'h600);
    upd(1, 32'h600, 8'h00, 1, 32'h700, 0, 32'h604);
    stats_clear = 1; #1;
    chk("rdw_hit", a_hit, 0);
    tick(); look(32'h600);
    chk("clr_total", a_total, 0);
    chk("clr_dir", a_dir, 0);
    chk("clr_tgt", a_tgt, 0);
    chk("clr_hit", a_hit, 1);
    chk("clr_target", a_target, 32'h700);
    upd(1, 32'h600, 8'h01, 1, 32'h700, 1, 32'h700); #1;
    chk("corr_misp", a_misp, 0);
    tick();
    chk("corr_total", a_total, 1);
    chk("corr_dir", a_dir, 0);

    // bimodal: different upd_ghr still lands on the same counter
    reset = 1; tick(); tick(); reset = 0;
    upd(1, 32'h100, 8'h00, 1, 32'h80, 0, 32'h104);
    tick(); look(32'h100);
    chk("bim_taken0", b_taken, 1);
    chk("bim_hit", b_hit, 1);
    upd(1, 32'h100, 8'hFF, 0, 32'h0, 1, 32'h80);
    tick(); look(32'h100);
    chk("bim_taken1", b_taken, 1);
    upd(1, 32'h100, 8'hFF, 0, 32'h0, 1, 32'h80);
    tick(); look(32'h100);
    chk("bim_taken2", b_taken, 0);
    chk("gsh_contrast", a_taken, 1);
    chk("bim_total", b_total, 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
